// File: rtl/ste_array_engine_pkg.sv
// ste_pkg: shared enums and sizing helpers for the STE array engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ste_pkg;

   // Start behaviour of one STE, held in attribute bits [1:0]
   typedef enum logic [1:0] {
      ST_NONE = 2'd0,
      ST_SOD  = 2'd1,
      ST_ALL  = 2'd2
   } start_type_e;

   // Target table of a configuration write
   typedef enum logic [1:0] {
      CFG_CLASS = 2'd0,
      CFG_EDGE  = 2'd1,
      CFG_ATTR  = 2'd2
   } cfg_type_e;

   // Engine sequencing state
   typedef enum logic [1:0] {
      S_CONFIG = 2'd0,
      S_RUN    = 2'd1,
      S_DRAIN  = 2'd2
   } state_e;

   // Number of 32-bit words making up one symbol class table
   function automatic int class_words(input int sym_w);
      return (1 << sym_w) / 32;
   endfunction

endpackage

// File: rtl/ste_array_engine_report_fifo.sv
// ste_report_fifo: synchronous FIFO for report records, with full/empty flags.
// Latency: a pushed entry is visible on rd_vld_o the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored; head stays stable until popped.
module ste_report_fifo #(
   parameter int W     = 48,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_vld_i,
   input  logic [W-1:0] wr_dat_i,
   output logic         rd_vld_o,
   input  logic         rd_rdy_i,
   output logic [W-1:0] rd_dat_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]   mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   cnt_q;
   logic             wr_en, rd_en;

   assign full_o   = (cnt_q == (PTR_W+1)'(DEPTH));
   assign empty_o  = (cnt_q == '0);
   assign rd_vld_o = !empty_o;
   assign rd_dat_o = mem_q[rd_ptr_q];
   assign wr_en    = wr_vld_i && !full_o;
   assign rd_en    = rd_rdy_i && !empty_o;

   // Storage, pointers and occupancy; pointers wrap naturally as DEPTH is a power of two
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({wr_en, rd_en})
            2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
            2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/ste_array_engine.sv
// ste_array_engine: runtime-programmable array of STEs scanning a symbol stream, reports queued in a FIFO.
// Latency: a report is on r_valid the cycle after the matching symbol is accepted.
// Backpressure: s_ready drops while the report FIFO is full; with STE_REPORT_DROP_EN reports are dropped instead.
module ste_array_engine
   import ste_pkg::*;
#(
   parameter int N_STE        = 16,
   parameter int SYM_W        = 8,
   parameter int REPORT_DEPTH = 8,
   parameter int OFFSET_W     = 32,
   localparam int STE_W       = (N_STE > 1) ? $clog2(N_STE) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cfg_we,
   input  logic [1:0]          cfg_type,
   input  logic [STE_W-1:0]    cfg_ste,
   input  logic [SYM_W-6:0]    cfg_word,
   input  logic [31:0]         cfg_data,
   input  logic                start,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [SYM_W-1:0]    s_data,
   input  logic                s_last,
   output logic                r_valid,
   input  logic                r_ready,
   output logic [OFFSET_W-1:0] r_offset,
   output logic [N_STE-1:0]    r_vector,
   output logic                busy,
   output logic                done,
   output logic [15:0]         drop_cnt
);
   localparam int CLASS_BITS = class_words(SYM_W) * 32;
   localparam int REC_W      = OFFSET_W + N_STE;

   logic [CLASS_BITS-1:0] class_q [N_STE];
   logic [N_STE-1:0]      edge_q  [N_STE];
   logic [1:0]            stype_q [N_STE];
   logic [N_STE-1:0]      report_q;

   state_e                state_q, state_d;
   logic                  done_q, done_d;
   logic [N_STE-1:0]      active_q;
   logic                  first_q;
   logic [OFFSET_W-1:0]   offset_q;

   logic [N_STE-1:0]      cfg_sel;
   logic [N_STE-1:0]      enable, active_next, rep_vec;
   logic                  accept, push_req, push;
   logic                  fifo_full, fifo_empty;
   logic [REC_W-1:0]      fifo_rd_dat;

   assign accept   = s_valid && s_ready;
   assign push_req = accept && (|rep_vec);
   assign done     = done_q;
   assign r_offset = fifo_rd_dat[REC_W-1 -: OFFSET_W];
   assign r_vector = fifo_rd_dat[N_STE-1:0];

`ifdef STE_REPORT_DROP_EN
   logic [15:0] drop_q;

   assign s_ready  = (state_q == S_RUN);
   assign push     = push_req && !fifo_full;
   assign drop_cnt = drop_q;

   // Count reports lost to a full FIFO, saturating; a new run starts from zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                 drop_q <= '0;
      else if (state_q == S_CONFIG && start)     drop_q <= '0;
      else if (push_req && fifo_full && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
   end
`else
   assign s_ready  = (state_q == S_RUN) && !fifo_full;
   assign push     = push_req;
   assign drop_cnt = '0;
`endif

   // Decode which STE a configuration write targets; writes only land in CONFIG
   always_comb begin
      cfg_sel = '0;
      for (int i = 0; i < N_STE; i++)
         cfg_sel[i] = cfg_we && (state_q == S_CONFIG) && (cfg_ste == STE_W'(i));
   end

   // Configuration tables: class bitmaps, incoming-edge masks, start/report attributes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_STE; i++) begin
            class_q[i] <= '0;
            edge_q[i]  <= '0;
            stype_q[i] <= ST_NONE;
         end
         report_q <= '0;
      end else begin
         for (int i = 0; i < N_STE; i++) begin
            if (cfg_sel[i]) begin
               case (cfg_type)
                  CFG_CLASS: class_q[i][{cfg_word, 5'd0} +: 32] <= cfg_data;
                  CFG_EDGE:  edge_q[i] <= cfg_data[N_STE-1:0];
                  CFG_ATTR: begin
                     stype_q[i]  <= cfg_data[1:0];
                     report_q[i] <= cfg_data[2];
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // Next-active computation for the symbol currently offered
   always_comb begin
      enable      = '0;
      active_next = '0;
      for (int i = 0; i < N_STE; i++) begin
         enable[i] = (stype_q[i] == ST_ALL) ||
                     ((stype_q[i] == ST_SOD) && first_q) ||
                     (|(edge_q[i] & active_q));
         active_next[i] = enable[i] && class_q[i][s_data];
      end
      rep_vec = active_next & report_q;
   end

   // Active vector, first-symbol flag and offset advance on each accepted symbol
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active_q <= '0;
         first_q  <= 1'b0;
         offset_q <= '0;
      end else if (state_q == S_CONFIG && start) begin
         active_q <= '0;
         first_q  <= 1'b1;
         offset_q <= '0;
      end else if (accept) begin
         active_q <= s_last ? '0 : active_next;
         first_q  <= 1'b0;
         offset_q <= offset_q + OFFSET_W'(1);
      end
   end

   // Sequencing state and registered done pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_CONFIG;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   // Next state: run on start, drain after the last symbol, return once reports are out
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      busy    = 1'b0;
      case (state_q)
         S_CONFIG: if (start) state_d = S_RUN;
         S_RUN: begin
            busy = 1'b1;
            if (accept && s_last) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (fifo_empty) begin
               state_d = S_CONFIG;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_CONFIG;
      endcase
   end

   ste_report_fifo #(
      .W     (REC_W),
      .DEPTH (REPORT_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_vld_i (push),
      .wr_dat_i ({offset_q, rep_vec}),
      .rd_vld_o (r_valid),
      .rd_rdy_i (r_ready),
      .rd_dat_o (fifo_rd_dat),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty)
   );

endmodule

// File: tb/tb_ste_array_engine.sv
// tb_ste_array_engine: directed scenarios with a report scoreboard for ste_array_engine.
// Latency: expected reports queued at stimulus time, compared as the DUT hands them out.
// Backpressure: r_ready is held low in selected scenarios to fill the report FIFO.
module tb_ste_array_engine;
   import ste_pkg::*;

   localparam int N  = 4;
   localparam int OW = 32;

   typedef struct packed {
      logic [OW-1:0] off;
      logic [N-1:0]  vec;
   } rep_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cfg_we = 1'b0;
   logic [1:0]    cfg_type = '0;
   logic [1:0]    cfg_ste = '0;
   logic [2:0]    cfg_word = '0;
   logic [31:0]   cfg_data = '0;
   logic          start = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [7:0]    s_data = '0;
   logic          s_last = 1'b0;
   logic          r_valid;
   logic          r_ready = 1'b1;
   logic [OW-1:0] r_offset;
   logic [N-1:0]  r_vector;
   logic          busy, done;
   logic [15:0]   drop_cnt;

   rep_t exp_q[$];
   int   vec_cnt = 0;
   int   err_cnt = 0;

   always #5 clk = ~clk;

   ste_array_engine #(
      .N_STE(N), .SYM_W(8), .REPORT_DEPTH(4), .OFFSET_W(OW)
   ) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_type(cfg_type), .cfg_ste(cfg_ste),
      .cfg_word(cfg_word), .cfg_data(cfg_data), .start(start), .s_valid(s_valid),
      .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .r_valid(r_valid),
      .r_ready(r_ready), .r_offset(r_offset), .r_vector(r_vector), .busy(busy),
      .done(done), .drop_cnt(drop_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every report taken by the consumer is matched against the queue
   always @(negedge clk) begin : mon
      rep_t e;
      if (r_valid && r_ready) begin
         if (exp_q.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL unexpected_report: got offset %0d vector %b expected none", r_offset, r_vector);
         end else begin
            e = exp_q.pop_front();
            check("r_offset", r_offset, e.off);
            check("r_vector", {28'd0, r_vector}, {28'd0, e.vec});
         end
      end
   end

   // All tasks start and end #1 after a rising edge
   task automatic cfg(input logic [1:0] t, input int ste, input int word, input logic [31:0] d);
      cfg_we = 1'b1; cfg_type = t; cfg_ste = 2'(ste); cfg_word = 3'(word); cfg_data = d;
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic class_char(input int ste, input int c);
      cfg(CFG_CLASS, ste, c / 32, 32'h1 << (c % 32));
   endtask

   task automatic class_all(input int ste);
      for (int w = 0; w < 8; w++) cfg(CFG_CLASS, ste, w, 32'hFFFF_FFFF);
   endtask

   task automatic go();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input bit last);
      int n;
      n = 0;
      s_valid = 1'b1; s_data = d; s_last = last;
      @(negedge clk);
      while (!s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         vec_cnt++;
         err_cnt++;
         $display("FAIL send_timeout: got s_ready 0 expected 1 for symbol %0h", d);
      end
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i], i == s.len() - 1);
   endtask

   task automatic wait_done(input string name);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (n < 100 && !seen) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         n++;
      end
      check({name, "_done"}, 32'(seen), 32'd1);
      @(posedge clk); #1;
      check({name, "_pending"}, exp_q.size(), 32'd0);
   endtask

   task automatic check_idle(input string name);
      check({name, "_s_ready"},  32'(s_ready), 0);
      check({name, "_r_valid"},  32'(r_valid), 0);
      check({name, "_r_offset"}, r_offset, 0);
      check({name, "_r_vector"}, 32'(r_vector), 0);
      check({name, "_busy"},     32'(busy), 0);
      check({name, "_done"},     32'(done), 0);
      check({name, "_drop_cnt"}, 32'(drop_cnt), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check_idle("reset");

      // Literal "--+"
      class_char(0, 45); cfg(CFG_ATTR, 0, 0, 32'd2);
      class_char(1, 45); cfg(CFG_EDGE, 1, 0, 32'd1);
      class_char(2, 43); cfg(CFG_EDGE, 2, 0, 32'd2); cfg(CFG_ATTR, 2, 0, 32'd4);
      exp_q.push_back('{off: 32'd3, vec: 4'b0100});
      go();
      check("lit_busy", 32'(busy), 1);
      send_str("a--+b");
      wait_done("lit");

      // Start-of-data
      do_reset();
      class_char(0, 120); cfg(CFG_ATTR, 0, 0, 32'd5);
      exp_q.push_back('{off: 32'd0, vec: 4'b0001});
      go(); send_str("xx"); wait_done("sod1");
      go(); send_str("ax"); wait_done("sod2");

      // Self-loop
      do_reset();
      class_char(0, 124); cfg(CFG_ATTR, 0, 0, 32'd2);
      for (int w = 0; w < 8; w++) cfg(CFG_CLASS, 1, w, (w == 0) ? ~32'h0000_2400 : 32'hFFFF_FFFF);
      cfg(CFG_EDGE, 1, 0, 32'd3); cfg(CFG_ATTR, 1, 0, 32'd4);
      exp_q.push_back('{off: 32'd1, vec: 4'b0010});
      exp_q.push_back('{off: 32'd2, vec: 4'b0010});
      go(); send_str("|ab\n"); wait_done("loop");

`ifndef STE_REPORT_DROP_EN
      // Backpressure with a 4-entry FIFO
      do_reset();
      class_all(0); cfg(CFG_ATTR, 0, 0, 32'd6);
      r_ready = 1'b0;
      for (int k = 0; k < 6; k++) exp_q.push_back('{off: 32'(k), vec: 4'b0001});
      go();
      for (int k = 0; k < 4; k++) send(8'(48 + k), 1'b0);
      s_valid = 1'b1; s_data = 8'd52;
      repeat (4) @(negedge clk);
      check("bp_s_ready", 32'(s_ready), 0);
      check("bp_r_valid", 32'(r_valid), 1);
      check("bp_head", r_offset, 0);
      @(posedge clk); #1;
      r_ready = 1'b1;
      send(8'd52, 1'b0);
      send(8'd53, 1'b1);
      wait_done("bp");
      check("bp_drop_cnt", 32'(drop_cnt), 0);
`else
      // Drop mode: FIFO never stalls the stream
      do_reset();
      class_all(0); cfg(CFG_ATTR, 0, 0, 32'd6);
      r_ready = 1'b0;
      go();
      for (int k = 0; k < 10; k++) begin
         send(8'(48 + k), k == 9);
         if (k < 9) check("drop_s_ready", 32'(s_ready), 1);
      end
      check("drop_cnt", 32'(drop_cnt), 6);
      for (int k = 0; k < 4; k++) exp_q.push_back('{off: 32'(k), vec: 4'b0001});
      r_ready = 1'b1;
      wait_done("drop");
      go();
      check("drop_clear", 32'(drop_cnt), 0);
      exp_q.push_back('{off: 32'd0, vec: 4'b0001});
      send(8'd122, 1'b1);
      wait_done("drop2");
`endif

      // Reset in the middle of a run
      do_reset();
      class_all(0); cfg(CFG_ATTR, 0, 0, 32'd6);
      r_ready = 1'b0;
      go();
      for (int k = 0; k < 3; k++) send(8'(97 + k), 1'b0);
      do_reset();
      check_idle("midreset");
      r_ready = 1'b1;
      go(); send_str("abc"); wait_done("postreset");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
